// File: rtl/wb_mem_slave_if.sv
// Wishbone target-side bundle for wb_mem_slave: cycle control, 64-bit split data and terminations.
interface wb_mem_slave_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic        wbs_cab_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat64_i;
    logic [31:0] wbs_dat_o;
    logic [31:0] wbs_dat64_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        wbs_rty_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i, wbs_sel_i,
               wbs_adr_i, wbs_dat_i, wbs_dat64_i,
        input  wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i, wbs_sel_i,
               wbs_adr_i, wbs_dat_i, wbs_dat64_i,
        output wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
    );
endinterface

// File: rtl/wb_mem_slave.sv
// Wishbone 64-bit-per-beat memory target with programmable wait states and CAB bursts.
// Optional range/wrap error termination is enabled by defining WB_MEM_ERR_EN.
module wb_mem_slave #(
    parameter int          AW   = 8,
    parameter logic [31:0] BASE = 32'h0,
    parameter int          WAIT = 1
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    wb_mem_slave_if.slave wbs
);
    localparam int          DEPTH  = 2 ** AW;
    localparam logic [3:0]  WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAITS, S_RESP} state_t;

    logic [63:0]   r_mem [DEPTH];
    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_adr;
    logic          r_ack;
    logic          r_err;
    logic [31:0]   r_dat;
    logic [31:0]   r_dat64;
    logic          r_oob;
    logic          r_wrap;

    logic          w_req;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_next;
    logic          w_oob0;
    logic          w_wrap_nx;
    logic          w_go;
    logic [AW-1:0] w_ld_adr;
    logic          w_ld_err;
    logic          w_unused;

    assign w_req  = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign w_idx  = wbs.wbs_adr_i[AW+2:3];
    assign w_next = r_adr + 1'b1;

`ifdef WB_MEM_ERR_EN
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd8 << AW);
    assign w_oob0    = (wbs.wbs_adr_i < BASE) || ({1'b0, wbs.wbs_adr_i} >= LIMIT);
    // Once the burst counter rolls past the top word every later beat is an error.
    assign w_wrap_nx = r_wrap | (r_adr == {AW{1'b1}});
`else
    assign w_oob0    = 1'b0;
    assign w_wrap_nx = r_wrap;
`endif

    assign w_unused = &{1'b0, wbs.wbs_sel_i, wbs.wbs_adr_i};

    // Decide whether the coming edge starts a response beat, and for which word.
    always_comb begin
        w_go     = 1'b0;
        w_ld_adr = r_adr;
        w_ld_err = 1'b0;
        case (r_state)
            S_IDLE: if (w_req && WAIT_C == 4'd0) begin
                w_go     = 1'b1;
                w_ld_adr = w_idx;
                w_ld_err = w_oob0;
            end
            S_WAITS: if (w_req && r_cnt == 4'd1) begin
                w_go     = 1'b1;
                w_ld_adr = r_adr;
                w_ld_err = r_oob;
            end
            S_RESP: if (w_req && wbs.wbs_cab_i) begin
                w_go     = 1'b1;
                w_ld_adr = w_next;
                w_ld_err = r_oob | w_wrap_nx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= 32'd0;
            r_dat64 <= 32'd0;
            r_oob   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (r_state == S_IDLE) begin
                r_oob  <= w_oob0;
                r_wrap <= 1'b0;
            end
            if (w_go) begin
                r_state <= S_RESP;
                r_adr   <= w_ld_adr;
                r_ack   <= ~w_ld_err;
                r_err   <= w_ld_err;
                r_dat   <= w_ld_err ? 32'd0 : r_mem[w_ld_adr][31:0];
                r_dat64 <= w_ld_err ? 32'd0 : r_mem[w_ld_adr][63:32];
                if (r_state == S_RESP)
                    r_wrap <= w_wrap_nx;
            end else begin
                case (r_state)
                    S_IDLE: if (w_req) begin
                        r_state <= S_WAITS;
                        r_cnt   <= WAIT_C;
                        r_adr   <= w_idx;
                    end
                    S_WAITS: begin
                        if (!w_req)
                            r_state <= S_IDLE;
                        else
                            r_cnt <= r_cnt - 4'd1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Write commits on the ack edge; an err beat never has r_ack set, so it cannot write.
    always_ff @(posedge wb_clk_i) begin
        if (r_ack && w_req && wbs.wbs_we_i)
            r_mem[r_adr] <= {wbs.wbs_dat64_i, wbs.wbs_dat_i};
    end

    assign wbs.wbs_ack_o   = r_ack;
    assign wbs.wbs_err_o   = r_err;
    assign wbs.wbs_dat_o   = r_dat;
    assign wbs.wbs_dat64_o = r_dat64;
    assign wbs.wbs_rty_o   = 1'b0;
endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: three instances (WAIT=1, WAIT=3, small ranged WAIT=0) against a word-array model.
module tb_wb_mem_slave;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, cab = 1'b0;
    logic [31:0] adr = 32'd0, dat = 32'd0, dat64 = 32'd0;
    int          dsel = 0;
    logic        ack_m, err_m;
    logic [31:0] dat_m, dat64_m;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          p_aw   [3] = '{8, 8, 4};
    int          p_wait [3] = '{1, 3, 0};
    logic [31:0] p_base [3] = '{32'h0, 32'h0, 32'h1000};
    logic [63:0] mdl    [3][256];

    wb_mem_slave_if if0 ();
    wb_mem_slave_if if1 ();
    wb_mem_slave_if if2 ();

    wb_mem_slave #(.AW(8), .BASE(32'h0),    .WAIT(1)) dut0 (.wb_clk_i(clk), .wb_rst_i(rst_n), .wbs(if0));
    wb_mem_slave #(.AW(8), .BASE(32'h0),    .WAIT(3)) dut1 (.wb_clk_i(clk), .wb_rst_i(rst_n), .wbs(if1));
    wb_mem_slave #(.AW(4), .BASE(32'h1000), .WAIT(0)) dut2 (.wb_clk_i(clk), .wb_rst_i(rst_n), .wbs(if2));

    always #5 clk = ~clk;

    assign if0.wbs_cyc_i = cyc && dsel == 0;
    assign if1.wbs_cyc_i = cyc && dsel == 1;
    assign if2.wbs_cyc_i = cyc && dsel == 2;
    assign if0.wbs_stb_i = stb;   assign if1.wbs_stb_i = stb;   assign if2.wbs_stb_i = stb;
    assign if0.wbs_we_i  = we;    assign if1.wbs_we_i  = we;    assign if2.wbs_we_i  = we;
    assign if0.wbs_cab_i = cab;   assign if1.wbs_cab_i = cab;   assign if2.wbs_cab_i = cab;
    assign if0.wbs_sel_i = 4'hF;  assign if1.wbs_sel_i = 4'hF;  assign if2.wbs_sel_i = 4'hF;
    assign if0.wbs_adr_i = adr;   assign if1.wbs_adr_i = adr;   assign if2.wbs_adr_i = adr;
    assign if0.wbs_dat_i = dat;   assign if1.wbs_dat_i = dat;   assign if2.wbs_dat_i = dat;
    assign if0.wbs_dat64_i = dat64; assign if1.wbs_dat64_i = dat64; assign if2.wbs_dat64_i = dat64;

    always_comb begin
        ack_m = if0.wbs_ack_o; err_m = if0.wbs_err_o; dat_m = if0.wbs_dat_o; dat64_m = if0.wbs_dat64_o;
        if (dsel == 1) begin
            ack_m = if1.wbs_ack_o; err_m = if1.wbs_err_o; dat_m = if1.wbs_dat_o; dat64_m = if1.wbs_dat64_o;
        end else if (dsel == 2) begin
            ack_m = if2.wbs_ack_o; err_m = if2.wbs_err_o; dat_m = if2.wbs_dat_o; dat64_m = if2.wbs_dat64_o;
        end
    end

    // One transaction of n beats (CAB when n>1); wmode 0=read 1=write 2=random, dmode 0=random 1=count 2=fixed.
    task automatic burst(input int d, input int n, input logic [31:0] a0, input int wmode, input int dmode);
        int          depth, w0, idx, wt;
        bit          ok, wr;
        logic        experr;
        logic [63:0] wd, rexp;
        depth = 1 << p_aw[d];
        w0    = int'(a0 >> 3) % depth;
        dsel  = d;
        for (int b = 0; b < n; b++) begin
            idx = (w0 + b) % depth;
            wr  = (wmode == 1) || (wmode == 2 && $urandom_range(0, 1) == 1);
            case (dmode)
                1:       wd = {32'h0, 32'(b + 1)};
                2:       wd = {32'h22222222, 32'h11111111};
                default: wd = {$urandom, $urandom};
            endcase
`ifdef WB_MEM_ERR_EN
            experr = (longint'(a0) < longint'(p_base[d])) ||
                     (longint'(a0) >= longint'(p_base[d]) + 8 * depth) || (w0 + b >= depth);
`else
            experr = 1'b0;
`endif
            cyc = 1'b1; stb = 1'b1; we = wr; cab = (b < n - 1);
            adr = (b == 0) ? a0 : $urandom;
            dat = wd[31:0]; dat64 = wd[63:32];
            if (b == 0) begin
                wt = 0; ok = 0;
                for (int k = 0; k < 40 && !ok; k++) begin
                    @(posedge clk); #1;
                    wt++;
                    if (ack_m || err_m) ok = 1;
                end
                n_checks++;
                if (!ok || wt != p_wait[d] + 1) begin
                    n_fail++;
                    $display("FAIL latency dut%0d adr=%h: got %0d cycles (responded=%0d) expected %0d",
                             d, a0, wt, ok, p_wait[d] + 1);
                    if (!ok) begin
                        cyc = 1'b0; stb = 1'b0; cab = 1'b0;
                        @(posedge clk); #1;
                        return;
                    end
                end
            end
            n_checks++;
            if ({ack_m, err_m} !== {~experr, experr}) begin
                n_fail++;
                $display("FAIL term dut%0d beat %0d: got ack/err=%b%b expected %b%b",
                         d, b, ack_m, err_m, ~experr, experr);
            end
            if (!wr) begin
                rexp = experr ? 64'd0 : mdl[d][idx];
                n_checks++;
                if ({dat64_m, dat_m} !== rexp) begin
                    n_fail++;
                    $display("FAIL rdata dut%0d beat %0d word %0d: got %h expected %h",
                             d, b, idx, {dat64_m, dat_m}, rexp);
                end
            end else if (!experr) begin
                mdl[d][idx] = wd;
            end
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; cab = 1'b0; we = 1'b0;
        n_checks++;
        if (ack_m !== 1'b0 || err_m !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after dut%0d: got ack/err=%b%b expected 00", d, ack_m, err_m);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({if0.wbs_ack_o, if0.wbs_err_o, if0.wbs_rty_o, if0.wbs_dat_o, if0.wbs_dat64_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset dut0: got %h expected 0",
                     {if0.wbs_ack_o, if0.wbs_err_o, if0.wbs_rty_o, if0.wbs_dat_o, if0.wbs_dat64_o});
        end
        n_checks++;
        if ({if1.wbs_ack_o, if1.wbs_err_o, if1.wbs_rty_o, if1.wbs_dat_o, if1.wbs_dat64_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset dut1: got %h expected 0",
                     {if1.wbs_ack_o, if1.wbs_err_o, if1.wbs_rty_o, if1.wbs_dat_o, if1.wbs_dat64_o});
        end
        n_checks++;
        if ({if2.wbs_ack_o, if2.wbs_err_o, if2.wbs_rty_o, if2.wbs_dat_o, if2.wbs_dat64_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset dut2: got %h expected 0",
                     {if2.wbs_ack_o, if2.wbs_err_o, if2.wbs_rty_o, if2.wbs_dat_o, if2.wbs_dat64_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        burst(0, 256, 32'h0, 1, 0);
        burst(1, 256, 32'h0, 1, 0);
        burst(2, 16, 32'h1000, 1, 0);
    endtask

    task automatic test_single();
        burst(0, 1, 32'h10, 1, 2);
        burst(0, 1, 32'h10, 0, 0);
    endtask

    task automatic test_cab();
        burst(1, 4, 32'h0, 1, 1);
        burst(1, 4, 32'h0, 0, 0);
    endtask

    task automatic test_abort();
        dsel = 1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cab = 1'b0;
        adr = 32'h8; dat = $urandom; dat64 = $urandom;
        @(posedge clk); #1;
        @(posedge clk); #1;
        stb = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ack_m !== 1'b0 || err_m !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_noack cycle %0d: got ack/err=%b%b expected 00", k, ack_m, err_m);
            end
        end
        cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        burst(1, 1, 32'h8, 0, 0);
    endtask

    task automatic test_reset_midburst();
        bit ok;
        dsel = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cab = 1'b1; adr = 32'h40;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clk); #1;
            if (ack_m) ok = 1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midburst_ack: got no ack within 40 cycles expected ack");
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ack_m, err_m, dat_m, dat64_m} !== 66'd0) begin
            n_fail++;
            $display("FAIL midburst_reset: got %h expected 0", {ack_m, err_m, dat_m, dat64_m});
        end
        cyc = 1'b0; stb = 1'b0; cab = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        burst(0, 2, 32'h40, 0, 0);
    endtask

    task automatic test_range();
        burst(2, 1, 32'h0800, 0, 0);
        burst(2, 2, 32'h1078, 0, 0);
        burst(2, 1, 32'h0FF8, 1, 0);
        burst(2, 1, 32'h1000, 0, 0);
    endtask

    task automatic test_random();
        int          d, n;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            d = $urandom_range(0, 2);
            n = $urandom_range(1, 6);
            if (d < 2)
                a = ($urandom_range(0, 7) == 0) ? ($urandom & 32'h0000_1FFF) : ($urandom & 32'h0000_07FF);
            else
                a = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_1FFF) : (32'h1000 | ($urandom & 32'h7F));
            burst(d, n, a, 2, 0);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single();
        test_cab();
        test_abort();
        test_reset_midburst();
        test_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
